// File: rtl/sprite_pkg.sv
// Shared FSM state type and 640x480 display timing constants for the sprite controller.
package sprite_pkg;

    typedef enum logic [1:0] {StIdle, StWait, StActive} state_e;

    localparam int unsigned H_RES      = 640;
    localparam int unsigned V_RES      = 480;
    localparam int unsigned H_RES_FULL = 800;
    localparam int unsigned V_RES_FULL = 525;

endpackage

// File: rtl/sprite_ctrl_if.sv
// Handshake between the sprite controller (master) and the sprite engine (slave).
interface sprite_ctrl_if #(
    parameter int unsigned CORDW = 10,
    parameter int unsigned ADDRW = 10
);
    logic [CORDW-1:0] sprx;
    logic [CORDW-1:0] spry;
    logic             spr_start;
    logic             spr_done;
    logic [ADDRW-1:0] frame_base;
    logic             busy;

    modport master (output sprx, spry, spr_start, frame_base, busy, input spr_done);
    modport slave  (input sprx, spry, spr_start, frame_base, busy, output spr_done);
endinterface

// File: rtl/sprite_pos_wrap.sv
// Combinational horizontal move by SPEED_X with modulo-H_RES_FULL wrap in either direction.
module sprite_pos_wrap #(
    parameter int unsigned CORDW      = 10,
    parameter int unsigned H_RES_FULL = 800,
    parameter int unsigned SPEED_X    = 2
) (
    input  logic [CORDW-1:0] pos_i,
    input  logic             dir_i,
    output logic [CORDW-1:0] pos_o
);
    localparam logic [CORDW:0] Speed = (CORDW+1)'(SPEED_X);
    localparam logic [CORDW:0] Full  = (CORDW+1)'(H_RES_FULL);

    logic [CORDW:0] pos_ext;
    logic [CORDW:0] sum;
    logic [CORDW:0] res;

    always_comb begin
        pos_ext = {1'b0, pos_i};
        sum     = pos_ext + Speed;
        if (dir_i) begin
            res = (sum >= Full) ? sum - Full : sum;
        end else begin
            // Position equal to SPEED_X lands on 0, keeping the result inside 0..H_RES_FULL-1.
            res = (pos_ext >= Speed) ? pos_ext - Speed : Full - (Speed - pos_ext);
        end
        pos_o = res[CORDW-1:0];
    end
endmodule

// File: rtl/sprite_ctrl.sv
// Sprite controller: starts the sprite engine once per frame and walks the sprite horizontally.
// Define SPRITE_CTRL_FRAME_EN to add animation frame sequencing on frame_base.
module sprite_ctrl #(
    parameter int unsigned CORDW      = 10,
    parameter int unsigned H_RES      = sprite_pkg::H_RES,
    parameter int unsigned V_RES      = sprite_pkg::V_RES,
    parameter int unsigned H_RES_FULL = sprite_pkg::H_RES_FULL,
    parameter int unsigned V_RES_FULL = sprite_pkg::V_RES_FULL,
    parameter int unsigned START_X    = 0,
    parameter int unsigned START_Y    = 200,
    parameter int unsigned SPEED_X    = 2,
    parameter int unsigned SPR_FRAMES = 1,
    parameter int unsigned SPR_PIXELS = 640,
    parameter int unsigned FRAME_RATE = 8,
    parameter int unsigned ADDRW      = 10
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             enable,
    input  logic             dir,
    sprite_ctrl_if.master    eng
);
    import sprite_pkg::*;

    localparam logic [CORDW-1:0] StartX = CORDW'(START_X);
    localparam logic [CORDW-1:0] StartY = CORDW'(START_Y);
    localparam logic [CORDW-1:0] SyStep = CORDW'(V_RES);
    localparam logic [CORDW-1:0] SxPre  = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] SyLast = CORDW'(V_RES_FULL - 1);

    state_e           state_q, state_d;
    logic [CORDW-1:0] sprx_q, sprx_d, spry_q, sprx_next, spry_cor;
    logic             start_q, start_d;
    logic             pend_q, pend_d;
    logic             step, apply;

    assign step     = enable && (sy == SyStep) && (sx == '0);
    assign spry_cor = (spry_q == '0) ? SyLast : spry_q - CORDW'(1);

    sprite_pos_wrap #(
        .CORDW      (CORDW),
        .H_RES_FULL (H_RES_FULL),
        .SPEED_X    (SPEED_X)
    ) u_pos_wrap (
        .pos_i (sprx_q),
        .dir_i (dir),
        .pos_o (sprx_next)
    );

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        pend_d  = pend_q;
        apply   = 1'b0;
        unique case (state_q)
            StIdle: begin
                apply = step;
                if (enable) state_d = StWait;
            end
            StWait: begin
                apply = step;
                if (!enable) begin
                    state_d = StIdle;
                end else if ((sy == spry_cor) && (sx == SxPre)) begin
                    state_d = StActive;
                    start_d = 1'b1;
                end
            end
            StActive: begin
                // Steps seen mid-sprite collapse into a single move once the engine is done.
                if (eng.spr_done) begin
                    state_d = enable ? StWait : StIdle;
                    apply   = pend_q || step;
                    pend_d  = 1'b0;
                end else if (step) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        sprx_d = apply ? sprx_next : sprx_q;
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sprx_q  <= StartX;
            spry_q  <= StartY;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sprx_q  <= sprx_d;
            start_q <= start_d;
            pend_q  <= pend_d;
        end
    end

    assign eng.sprx      = sprx_q;
    assign eng.spry      = spry_q;
    assign eng.spr_start = start_q;
    assign eng.busy      = (state_q == StActive);

`ifdef SPRITE_CTRL_FRAME_EN
    localparam int unsigned CntW = (FRAME_RATE > 1) ? $clog2(FRAME_RATE) : 1;
    localparam int unsigned IdxW = (SPR_FRAMES > 1) ? $clog2(SPR_FRAMES) : 1;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [ADDRW-1:0] base_q, base_d;

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        base_d = base_q;
        if (apply) begin
            if (cnt_q == CntW'(FRAME_RATE - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IdxW'(SPR_FRAMES - 1)) ? '0 : idx_q + IdxW'(1);
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
            base_d = ADDRW'(32'(idx_d) * SPR_PIXELS);
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            base_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            base_q <= base_d;
        end
    end

    assign eng.frame_base = base_q;
`else
    assign eng.frame_base = '0;
`endif
endmodule

// File: tb/tb_sprite_ctrl.sv
// Directed bench for sprite_ctrl: an even-start and an odd-start instance share all stimulus.
module tb_sprite_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sx, sy;
    logic       enable, dir, spr_done;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_start = 0;
    int n_app   = 0;

    sprite_ctrl_if #(.CORDW(10), .ADDRW(11)) eng ();
    sprite_ctrl_if #(.CORDW(10), .ADDRW(11)) eng_odd ();

    assign eng.spr_done     = spr_done;
    assign eng_odd.spr_done = spr_done;

    sprite_ctrl #(
        .START_X    (0),
        .SPR_FRAMES (3),
        .FRAME_RATE (2),
        .ADDRW      (11)
    ) dut (
        .clk_pix (clk),
        .rst     (rst),
        .sx      (sx),
        .sy      (sy),
        .enable  (enable),
        .dir     (dir),
        .eng     (eng)
    );

    sprite_ctrl #(
        .START_X    (1),
        .SPR_FRAMES (3),
        .FRAME_RATE (2),
        .ADDRW      (11)
    ) dut_odd (
        .clk_pix (clk),
        .rst     (rst),
        .sx      (sx),
        .sy      (sy),
        .enable  (enable),
        .dir     (dir),
        .eng     (eng_odd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (eng.spr_start === 1'b1) n_start++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int frame_exp(input int n);
`ifdef SPRITE_CTRL_FRAME_EN
        return ((n / 2) % 3) * 640;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int x, input int y);
        sx = 10'(x);
        sy = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic d, input int ex, input int ex_odd);
        dir = d;
        tick(0, 480);
        n_app++;
        check_eq("step_sprx", eng.sprx, ex);
        check_eq("step_sprx_odd", eng_odd.sprx, ex_odd);
        check_eq("step_frame_base", eng.frame_base, frame_exp(n_app));
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; dir = 1'b0; spr_done = 1'b0; sx = '0; sy = '0;
        #1 rst = 1'b1;
        #10;
        check_eq("rst_sprx", eng.sprx, 0);
        check_eq("rst_sprx_odd", eng_odd.sprx, 1);
        check_eq("rst_spry", eng.spry, 200);
        check_eq("rst_start", eng.spr_start, 0);
        check_eq("rst_busy", eng.busy, 0);
        check_eq("rst_frame_base", eng.frame_base, 0);

        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b1;
        tick(100, 100);
        tick(101, 100);
        check_eq("wait_busy", eng.busy, 0);

        // Start pulse on line 199 at sx 640
        tick(638, 199);
        check_eq("pre_start", eng.spr_start, 0);
        tick(639, 199);
        check_eq("start_pulse", eng.spr_start, 1);
        check_eq("start_busy", eng.busy, 1);
        tick(640, 199);
        check_eq("start_one_cycle", eng.spr_start, 0);
        check_eq("active_busy", eng.busy, 1);
        check_eq("start_count1", n_start, 1);

        spr_done = 1'b1; tick(10, 220); spr_done = 1'b0;
        check_eq("done_busy", eng.busy, 0);
        spr_done = 1'b1; tick(11, 220); spr_done = 1'b0;
        check_eq("stray_done_busy", eng.busy, 0);
        check_eq("stray_done_start", eng.spr_start, 0);

        tick(1, 480);
        check_eq("no_step_sx1", eng.sprx, 0);
        do_step(1'b1, 2, 3);
        do_step(1'b0, 0, 1);
        do_step(1'b0, 798, 799);
        do_step(1'b1, 0, 1);

        enable = 1'b0;
        tick(0, 480);
        check_eq("disabled_step", eng.sprx, 0);
        check_eq("disabled_frame", eng.frame_base, frame_exp(n_app));
        enable = 1'b1;
        tick(5, 300);

        // Two steps during a long sprite merge into one move after spr_done
        dir = 1'b1;
        tick(639, 199);
        check_eq("pend_busy", eng.busy, 1);
        tick(0, 480);
        check_eq("pend_hold1", eng.sprx, 0);
        tick(0, 480);
        check_eq("pend_hold2", eng.sprx, 0);
        spr_done = 1'b1; tick(20, 10); spr_done = 1'b0;
        n_app++;
        check_eq("pend_apply", eng.sprx, 2);
        check_eq("pend_apply_odd", eng_odd.sprx, 3);
        check_eq("pend_frame", eng.frame_base, frame_exp(n_app));
        tick(21, 10);
        check_eq("pend_once", eng.sprx, 2);
        do_step(1'b0, 0, 1);
        check_eq("start_count2", n_start, 2);

        // Enable falling mid-sprite lets it finish, then no new start
        tick(639, 199);
        enable = 1'b0;
        tick(30, 250);
        check_eq("no_abort_busy", eng.busy, 1);
        spr_done = 1'b1; tick(31, 250); spr_done = 1'b0;
        check_eq("idle_busy", eng.busy, 0);
        tick(638, 199);
        tick(639, 199);
        tick(640, 199);
        check_eq("idle_no_start", n_start, 3);

        // Asynchronous reset mid-sprite
        enable = 1'b1;
        tick(1, 1);
        do_step(1'b1, 2, 3);
        tick(639, 199);
        enable = 1'b0;
        tick(40, 250);
        check_eq("pre_rst_busy", eng.busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_busy", eng.busy, 0);
        check_eq("async_sprx", eng.sprx, 0);
        check_eq("async_sprx_odd", eng_odd.sprx, 1);
        check_eq("async_start", eng.spr_start, 0);
        check_eq("async_frame", eng.frame_base, 0);
        #2 rst = 1'b0;
        n_app = 0;
        @(posedge clk); #1;
        tick(639, 199);
        tick(640, 199);
        enable = 1'b1;
        tick(0, 0);
        tick(639, 300);
        tick(639, 198);
        tick(640, 198);
        check_eq("post_rst_no_start", n_start, 4);
        check_eq("post_rst_busy", eng.busy, 0);
        tick(639, 199);
        check_eq("post_rst_start", eng.spr_start, 1);
        tick(640, 199);
        check_eq("post_rst_count", n_start, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
